// File: rtl/pipe_skid_register.sv
// -----------------------------------------------------------------------------
// pipe_skid_register
//
// Two-entry ready/valid pipeline register with a skid slot. in_ready depends
// only on registered state, so there is no combinational path from out_ready
// back to in_ready. This lets the block break long ready chains while still
// sustaining one entry per cycle.
//
// Parameters
//   WIDTH  payload width in bits (must be > 0)
//   RESET  bit value replicated across both data registers at reset
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-low reset
//   flush      discard all held entries (data registers untouched)
//   in_valid   upstream entry present
//   in_data    upstream payload
//   in_ready   block can accept an entry this cycle
//   out_valid  out_data holds a valid entry
//   out_data   oldest held entry (main register)
//   out_ready  downstream consumes the entry this cycle
//   count      number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_skid_register #(
  parameter int   WIDTH = 64,
  parameter logic RESET = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  generate
    if (WIDTH <= 0) begin : g_width_check
      $error("pipe_skid_register: WIDTH must be greater than 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_accept;
  logic w_fire;
  logic w_load_main;
  logic w_main_from_skid;
  logic w_load_skid;

  // Handshake outputs come straight from registered state.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;

  assign w_accept = in_valid & in_ready;
  assign w_fire   = out_valid & out_ready;

  always_comb begin
    count = 2'd0;
    case (r_state)
      ST_ONE:  count = 2'd1;
      ST_TWO:  count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // Next-state and data-load decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;

    if (flush) begin
      // Flush drops every entry and wins over any handshake this cycle;
      // data registers are left alone.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_main = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_fire) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the skid entry can advance.
          if (w_fire) begin
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_main  <= {WIDTH{RESET}};
      r_skid  <= {WIDTH{RESET}};
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : in_data;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: doc/pipe_skid_register.md
PIPE_SKID_REGISTER -- requirements
Module: pipe_skid_register

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width in bits; WIDTH > 0 SHALL be asserted at elaboration.
REQ-002 SHALL have parameter RESET, default 1'b0, bit value replicated across all WIDTH bits of both data registers at reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-005 SHALL have port flush  input  1  discard all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_data  input  WIDTH  upstream entry payload.
REQ-008 SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_data  output  WIDTH  oldest held entry.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 SHALL have port count  output  2  number of held entries, 0..2.

Function
REQ-013 SHALL hold up to two entries: a main register driving out_data and a skid register.
REQ-014 SHALL use states EMPTY (count 0), ONE (main full, count 1), and TWO (main and skid full, count 2).
REQ-015 SHALL derive in_ready from state only: 1 in EMPTY and ONE, 0 in TWO, so in_ready has no combinational path from out_ready.
REQ-016 SHALL define out_valid = (state != EMPTY) and out_data = main register.
REQ-017 SHALL define accept = in_valid & in_ready and fire = out_valid & out_ready.
REQ-018 In EMPTY: on accept, SHALL load main <= in_data and go to ONE; otherwise SHALL stay in EMPTY.
REQ-019 In ONE with accept & fire: SHALL load main <= in_data and stay in ONE.
REQ-020 In ONE with accept & !fire: SHALL load skid <= in_data and go to TWO.
REQ-021 In ONE with !accept & fire: SHALL go to EMPTY.
REQ-022 In ONE with no accept and no fire: SHALL hold.
REQ-023 In TWO with fire: SHALL load main <= skid and go to ONE; otherwise SHALL hold.
REQ-024 Latency: an entry accepted at edge N SHALL be visible on out_valid/out_data after edge N (zero bubbles when EMPTY or ONE).
REQ-025 Throughput SHALL be one entry per cycle with out_ready held high.
REQ-026 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-027 Data registers SHALL change only on the loads listed above; when EMPTY, out_data SHALL keep its last value.
REQ-028 Flush (flush==1, reset==1) SHALL force state EMPTY at the edge, overriding any accept or fire in that cycle.
REQ-029 On flush, data registers SHALL be unchanged and in_data SHALL be ignored.
REQ-030 Holding out_data SHALL NOT require out_ready: while out_valid & !out_ready, out_data SHALL be stable.

Reset
REQ-031 reset==0 at an edge SHALL force state EMPTY and set main and skid to {WIDTH{RESET}}, overriding flush, accept and fire.
REQ-032 After reset: out_valid=0, count=0, in_ready=1, out_data={WIDTH{RESET}}.
REQ-033 Reset asserted while in TWO SHALL discard both entries; the first post-reset accept SHALL appear as the only entry.

Verification
REQ-034 Reset, then in_valid=1 with in_data=32 and out_ready=0 -> count=1, out_valid=1, out_data=32, in_ready=1.
REQ-035 From the REQ-034 state, in_data=43 with out_ready=0 -> count=2, in_ready=0, out_data=32; next cycle out_ready=1 -> out_data=43, count=1.
REQ-036 Stream 1,2,3,4 with in_valid=1 and out_ready=1 every cycle -> out_data 1,2,3,4 on consecutive cycles, count stays 1, in_ready stays 1.
REQ-037 With count=2, assert flush together with in_valid=1, in_data=99 -> count=0, out_valid=0, in_ready=1, and 99 is never output.
REQ-038 With count=2, drive reset=0 together with flush=1 -> count=0, out_data=0 for RESET=0; repeat with RESET=1, WIDTH=8 -> out_data=8'hFF.
REQ-039 Random in_valid/out_ready over at least 10,000 cycles with a scoreboard -> output sequence equals accepted sequence, count never exceeds 2, no output while out_valid=0.
